uart_tx_fifo: RTL and testbench

//   Synthesizable 8N1 UART transmitter with a small write-side FIFO; drives the serial

---
 rtl/uart_tx_fifo_if.sv | 28 ++
 rtl/uart_tx_fifo.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Purpose  : Byte write handshake between bus/firmware logic and the UART
//            transmitter FIFO (valid/ready, push = tx_valid & tx_ready).
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  // Producer side: offers bytes, observes back-pressure
  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  // Transmitter side: accepts bytes, drives back-pressure
  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : 8N1 UART transmitter fed by a small write-side FIFO. Bytes are
//            sent LSB first at a runtime clocks-per-bit divisor that is
//            sampled at the start of every frame. Idle line is high.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_WIDTH  = 4
) (
  input  wire                  clk,
  input  wire                  resetn,
  input  wire [DIV_WIDTH-1:0]  cfg_divisor,
  uart_tx_fifo_if.slave        tx_bus,
  output logic                 ser_tx,
  output logic                 busy,
  output logic [LVL_WIDTH-1:0] fifo_level
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [LVL_WIDTH-1:0] c_LVL_FULL = LVL_WIDTH'(FIFO_DEPTH);
  localparam logic [LVL_WIDTH-1:0] c_LVL_ONE  = LVL_WIDTH'(1);
  localparam logic [LVL_WIDTH-1:0] c_LVL_ZERO = '0;
  localparam logic [AW-1:0]        c_PTR_ONE  = AW'(1);
  localparam logic [DIV_WIDTH-1:0] c_DIV_MIN  = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] c_DIV_ONE  = DIV_WIDTH'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [LVL_WIDTH-1:0] r_level;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit;
  logic [DIV_WIDTH-1:0] r_baud;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_ser;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_ready;
  logic                 w_baud_last;
  logic                 w_ser_nxt;
  logic [DIV_WIDTH-1:0] w_div_eff;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  assign w_empty     = (r_level == c_LVL_ZERO);
  assign w_ready     = (r_level != c_LVL_FULL);
  assign w_push      = tx_bus.tx_valid & w_ready;
  // Divisors below 2 would collapse a bit to a single clock; clamp to 2
  assign w_div_eff   = (cfg_divisor < c_DIV_MIN) ? c_DIV_MIN : cfg_divisor;
  // r_div is never below 2, so the subtraction cannot wrap
  assign w_baud_last = (r_baud == (r_div - c_DIV_ONE));

  assign tx_bus.tx_ready = w_ready;
  assign ser_tx          = r_ser;
  assign busy            = (r_state != S_IDLE) | ~w_empty;
  assign fifo_level      = r_level;

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  // Write accepted bytes into the storage array (contents need no reset)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= tx_bus.tx_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-2 depth
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_ONE;
        2'b01:   r_level <= r_level - c_LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: each non-idle state lasts one baud period (DATA lasts eight)
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_last && (r_bit == 3'd7)) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_baud_last) begin
          w_state_nxt = w_empty ? S_IDLE : S_START;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: FIFO pop at frame start and the line level for the current state
  always_comb begin
    w_pop     = 1'b0;
    w_ser_nxt = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_pop = ~w_empty;
      end
      S_START: begin
        w_ser_nxt = 1'b0;
      end
      S_DATA: begin
        w_ser_nxt = r_shift[0];
      end
      S_STOP: begin
        // Back-to-back frames: pop on the last stop cycle so there is no gap
        w_pop = w_baud_last & ~w_empty;
      end
      default: begin
        w_pop     = 1'b0;
        w_ser_nxt = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  // Shift register, bit index and baud counter; divisor frozen per frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shift <= '0;
      r_bit   <= '0;
      r_baud  <= '0;
      r_div   <= c_DIV_MIN;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rptr];
      r_bit   <= '0;
      r_baud  <= '0;
      r_div   <= w_div_eff;
    end else if (r_state != S_IDLE) begin
      if (w_baud_last) begin
        r_baud <= '0;
        if (r_state == S_DATA) begin
          r_shift <= {1'b0, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
        end
      end else begin
        r_baud <= r_baud + c_DIV_ONE;
      end
    end
  end

  // Registered serial line; a reset drives it high without waiting for a clock
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ser <= 1'b1;
    end else begin
      r_ser <= w_ser_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo. A frame-timing model
//            predicts the line, level, ready and busy every cycle; directed
//            scenarios decode the recorded line against literal bytes/timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int LW    = 4;
  localparam int HIST  = 40000;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] cfg_divisor;
  logic          ser_tx;
  logic          busy;
  logic [LW-1:0] fifo_level;

  uart_tx_fifo_if bus();

  uart_tx_fifo #(
    .DIV_WIDTH  (DW),
    .FIFO_DEPTH (DEPTH),
    .LVL_WIDTH  (LW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cfg_divisor (cfg_divisor),
    .tx_bus      (bus),
    .ser_tx      (ser_tx),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a queue of bytes and a frame timer counting 0..10*D-1.
  // The line level is derived arithmetically from the elapsed time; it shows
  // up on ser_tx one clock after the frame timer reaches it.
  // --------------------------------------------------------------------------
  byte unsigned m_q[$];
  bit           m_active = 1'b0;
  int           m_t      = 0;
  int           m_D      = 2;
  logic [7:0]   m_byte   = 8'h00;
  bit           m_ser    = 1'b1;
  int           m_pre;
  bit           m_start;

  function automatic bit slot_bit(input int t, input int D, input logic [7:0] b);
    int s;
    s = t / D;
    if (s == 0) return 1'b0;
    if (s >= 9) return 1'b1;
    return b[s-1];
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_q.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ser    = 1'b1;
    end else begin
      m_pre   = m_q.size();
      m_ser   = m_active ? slot_bit(m_t, m_D, m_byte) : 1'b1;
      m_start = 1'b0;
      if (m_active) begin
        if (m_t == 10 * m_D - 1) begin
          m_active = 1'b0;
          m_start  = (m_pre > 0);
        end else begin
          m_t++;
        end
      end else begin
        m_start = (m_pre > 0);
      end
      if (m_start) begin
        m_byte   = m_q.pop_front();
        m_D      = (cfg_divisor < 2) ? 2 : int'(cfg_divisor);
        m_t      = 0;
        m_active = 1'b1;
      end
      if (bus.tx_valid && (m_pre < DEPTH)) begin
        m_q.push_back(bus.tx_data);
      end
    end
  end

  // Every-cycle comparison against the model, plus line history recording
  bit hist [HIST];
  int ncyc = 0;

  always @(negedge clk) begin
    check("ser_tx",     int'(ser_tx),       int'(m_ser));
    check("fifo_level", int'(fifo_level),   m_q.size());
    check("tx_ready",   int'(bus.tx_ready), int'(m_q.size() < DEPTH));
    check("busy",       int'(busy),         int'(m_active || (m_q.size() != 0)));
    if (ncyc < HIST) begin
      hist[ncyc] = ser_tx;
      ncyc++;
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b, output int waited);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    do begin
      acc = bus.tx_ready;
      step();
      n++;
    end while (!acc && (n < 5000));
    bus.tx_valid = 1'b0;
    waited = n;
    check("push_accepted", int'(acc), 1);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && (n < bound)) begin
      step();
      n++;
    end
    check("idle_reached", int'(busy), 0);
    repeat (3) step();
  endtask

  // Find the next start bit at or after 'from' and sample each bit mid-slot
  function automatic void decode(input int from, input int D, output int fall, output int val);
    int lo;
    fall = -1;
    val  = -1;
    lo   = (from > 0) ? from : 1;
    for (int i = lo; i < ncyc; i++) begin
      if (hist[i-1] && !hist[i]) begin
        fall = i;
        break;
      end
    end
    if (fall < 0) return;
    if (fall + 9 * D + D / 2 >= ncyc) return;
    val = 0;
    for (int k = 0; k < 8; k++) begin
      if (hist[fall + D * (k + 1) + D / 2]) val = val | (1 << k);
    end
    if (!hist[fall + 9 * D + D / 2]) val = -2;
  endfunction

  function automatic int lowrun(input int from);
    int n;
    n = 0;
    while ((from + n < ncyc) && !hist[from + n]) n++;
    return n;
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int         w;
  int         from;
  int         f1, f2, f3;
  int         v;
  logic [9:0] pat;
  logic [7:0] b4;

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    cfg_divisor  = 16'd10;
    resetn       = 1'b0;

    // Reset held with a byte offered: nothing is accepted, line stays high
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hAA;
    repeat (4) step();
    check("t1_ser_high", int'(ser_tx),     1);
    check("t1_level0",   int'(fifo_level), 0);
    check("t1_busy0",    int'(busy),       0);
    check("t1_ready1",   int'(bus.tx_ready), 1);
    bus.tx_valid = 1'b0;
    resetn = 1'b1;
    repeat (2) step();

    // 0x55 at divisor 10: start bit two clocks after the push, alternating bits
    cfg_divisor = 16'd10;
    pat = 10'b1010101010;
    push(8'h55, w);
    for (int j = 0; j < 106; j++) begin
      @(negedge clk);
      if (j == 1)   check("t2_still_high", int'(ser_tx), 1);
      if (j == 2)   check("t2_start_low",  int'(ser_tx), 0);
      if ((j >= 2) && (j < 102) && (((j - 2) % 10) == 5))
        check("t2_slot", int'(ser_tx), int'(pat[(j - 2) / 10]));
      if (j == 100) check("t2_busy_last",  int'(busy), 1);
      if (j == 101) check("t2_busy_clear", int'(busy), 0);
      if (j == 105) check("t2_idle_high",  int'(ser_tx), 1);
    end
    step();

    // Three back-to-back frames at divisor 4
    cfg_divisor = 16'd4;
    from = ncyc;
    push(8'h41, w);
    push(8'h42, w);
    push(8'h0A, w);
    wait_idle(500);
    decode(from, 4, f1, v);
    check("t3_byte0", v, 32'h41);
    decode(f1 + 40, 4, f2, v);
    check("t3_byte1", v, 32'h42);
    check("t3_gap01", f2 - f1, 40);
    decode(f2 + 40, 4, f3, v);
    check("t3_byte2", v, 32'h0A);
    check("t3_gap12", f3 - f2, 40);

    // Fill the FIFO while a slow frame is on the line
    cfg_divisor = 16'd100;
    from = ncyc;
    push(8'h80, w);
    for (int i = 1; i <= 8; i++) begin
      b4 = 8'h80 + 8'(i);
      push(b4, w);
    end
    check("t4_level_full", int'(fifo_level),   8);
    check("t4_not_ready",  int'(bus.tx_ready), 0);
    push(8'h89, w);
    check("t4_stall_cycles", w, 994);
    wait_idle(12000);
    f1 = from;
    for (int i = 0; i < 10; i++) begin
      decode(f1, 100, f2, v);
      check("t4_order", v, 32'h80 + i);
      f1 = f2 + 1000;
    end

    // Asynchronous reset during data bit 3 of 0xA5
    cfg_divisor = 16'd10;
    push(8'hA5, w);
    repeat (45) step();
    check("t5_bit3_low", int'(ser_tx), 0);
    #1;
    resetn = 1'b0;
    #1;
    check("t5_ser_async", int'(ser_tx),     1);
    check("t5_level0",    int'(fifo_level), 0);
    check("t5_busy0",     int'(busy),       0);
    repeat (3) step();
    resetn = 1'b1;
    repeat (2) step();
    from = ncyc;
    push(8'h3C, w);
    wait_idle(500);
    decode(from, 10, f1, v);
    check("t5_after_reset", v, 32'h3C);

    // Divisor 0 behaves as 2
    cfg_divisor = 16'd0;
    from = ncyc;
    push(8'hFF, w);
    wait_idle(200);
    decode(from, 2, f1, v);
    check("t6_div0_byte", v, 32'hFF);
    check("t6_div0_width", lowrun(f1), 2);

    // Divisor change mid-frame applies from the next frame
    cfg_divisor = 16'd4;
    from = ncyc;
    push(8'hFF, w);
    push(8'hFF, w);
    repeat (10) step();
    cfg_divisor = 16'd8;
    wait_idle(500);
    decode(from, 4, f1, v);
    check("t6_first_width", lowrun(f1), 4);
    decode(f1 + 40, 8, f2, v);
    check("t6_frame1_len",   f2 - f1, 40);
    check("t6_second_width", lowrun(f2), 8);
    check("t6_second_byte",  v, 32'hFF);

    // Random traffic with occasional divisor changes
    for (int i = 0; i < 1500; i++) begin
      bus.tx_valid = ($urandom_range(0, 3) == 0);
      bus.tx_data  = 8'($urandom);
      if ($urandom_range(0, 99) == 0) cfg_divisor = 16'($urandom_range(0, 6));
      step();
    end
    bus.tx_valid = 1'b0;
    wait_idle(20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
